// File: rtl/bexkat_irq_pkg.sv
// Shared definitions for the bexkat2 interrupt controller: register offsets,
// source indices and the per-source interrupt code table.
package bexkat_irq_pkg;

    localparam int IRQ_NSRC = 7;

    localparam logic [2:0] IRQ_STATUS  = 3'd0;
    localparam logic [2:0] IRQ_PENDING = 3'd1;
    localparam logic [2:0] IRQ_MASK    = 3'd2;
    localparam logic [2:0] IRQ_EDGE    = 3'd3;
    localparam logic [2:0] IRQ_CLEAR   = 3'd4;
    localparam logic [2:0] IRQ_ACTIVE  = 3'd5;

    localparam int SRC_MMU     = 6;
    localparam int SRC_TIMER3  = 5;
    localparam int SRC_TIMER2  = 4;
    localparam int SRC_TIMER1  = 3;
    localparam int SRC_TIMER0  = 2;
    localparam int SRC_UART_RX = 1;
    localparam int SRC_UART_TX = 0;

    // Code presented to the CPU for each source, indexed by source number.
    localparam logic [2:0] SRC_CODE [0:IRQ_NSRC-1] =
        '{3'd7, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};

endpackage

// File: rtl/irq_prio_encode.sv
// Combinational priority encoder: the highest-numbered active source wins and
// its code is looked up in the package table; no active source gives 0.
module irq_prio_encode
    import bexkat_irq_pkg::*;
#(
    parameter int NSRC = IRQ_NSRC
) (
    input  logic [NSRC-1:0] vec_i,
    output logic [2:0]      code_o
);

    always_comb begin
        // NOTE: assign a default first so every path drives code_o and no latch is inferred.
        code_o = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (vec_i[i]) code_o = SRC_CODE[i];
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Registered interrupt controller in front of the bexkat2 CPU: per-source mask,
// edge/level mode, sticky edge-pending bits and a Wishbone register interface.
module irq_controller
    import bexkat_irq_pkg::*;
#(
    parameter int              NSRC       = IRQ_NSRC,
    parameter logic [NSRC-1:0] MASK_RESET = 7'h7F
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [2:0]      adr_i,
    input  logic [31:0]     dat_i,
    output logic [31:0]     dat_o,
    input  logic            we_i,
    input  logic [3:0]      sel_i,
    input  logic            stb_i,
    input  logic            cyc_i,
    output logic            ack_o,
    input  logic [NSRC-1:0] irq_i,
    input  logic            int_en,
    output logic [2:0]      interrupt
);

    logic [NSRC-1:0] irq_q, irq_qq;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_q, edge_d;
    logic [2:0]      interrupt_q, interrupt_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;

    logic            bus_hit, wr_en;
    logic [NSRC-1:0] clr, eff;
    logic [2:0]      code;
    logic [31:0]     rd_data;
    logic            unused_bits;

    assign unused_bits = ^{sel_i[3:1], dat_i[31:NSRC]};

    irq_prio_encode #(.NSRC(NSRC)) u_encode (
        .vec_i  (eff),
        .code_o (code)
    );

    always_comb begin
        bus_hit = stb_i & cyc_i & ~ack_q;
        wr_en   = bus_hit & we_i & sel_i[0];
        ack_d   = bus_hit;
        mask_d  = mask_q;
        edge_d  = edge_q;
        clr     = '0;

        if (wr_en) begin
            case (adr_i)
                IRQ_MASK:  mask_d = dat_i[NSRC-1:0];
                IRQ_EDGE:  edge_d = dat_i[NSRC-1:0];
                IRQ_CLEAR: clr    = dat_i[NSRC-1:0];
                default:   ;
            endcase
        end
        // The MMU fault is always level-sensitive and can never be masked.
        mask_d[SRC_MMU] = 1'b1;
        edge_d[SRC_MMU] = 1'b0;

        // New edges are ORed in after the clear so a coincident event survives;
        // leaving edge mode discards the sticky bit immediately.
        pending_d = ((pending_q & ~clr) | (irq_q & ~irq_qq & edge_q)) & edge_d;

        eff         = mask_q & ((edge_q & pending_q) | (~edge_q & irq_q));
        interrupt_d = int_en ? code : 3'd0;

        rd_data = '0;
        case (adr_i)
            IRQ_STATUS:  rd_data[NSRC-1:0] = irq_q;
            IRQ_PENDING: rd_data[NSRC-1:0] = pending_q;
            IRQ_MASK:    rd_data[NSRC-1:0] = mask_q;
            IRQ_EDGE:    rd_data[NSRC-1:0] = edge_q;
            IRQ_ACTIVE:  rd_data[2:0]      = interrupt_q;
            default:     rd_data           = '0;
        endcase
        dat_d = (bus_hit & ~we_i) ? rd_data : '0;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            irq_q       <= '0;
            irq_qq      <= '0;
            pending_q   <= '0;
            mask_q      <= MASK_RESET;
            edge_q      <= '0;
            interrupt_q <= 3'd0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            irq_q       <= irq_i;
            irq_qq      <= irq_q;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            interrupt_q <= interrupt_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    assign ack_o     = ack_q;
    assign dat_o     = dat_q;
    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller: register access, level/edge sources,
// set-vs-clear race, masking, global enable and reset during a bus cycle.
module tb_irq_controller;
    import bexkat_irq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we_i  = 1'b0;
    logic [3:0]  sel_i = '0;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        ack_o;
    logic [6:0]  irq_i = '0;
    logic        int_en = 1'b0;
    logic [2:0]  interrupt;

    int vectors     = 0;
    int miscompares = 0;

    irq_controller dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .we_i      (we_i),
        .sel_i     (sel_i),
        .stb_i     (stb_i),
        .cyc_i     (cyc_i),
        .ack_o     (ack_o),
        .irq_i     (irq_i),
        .int_en    (int_en),
        .interrupt (interrupt)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Returns 32'hDEAD_BEEF if no acknowledge arrives, which no register can hold.
    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bit got = 1'b0;
        d = 32'hDEAD_BEEF;
        adr_i = a; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
        for (int n = 0; n < 4 && !got; n++) begin
            tick();
            if (ack_o) begin
                got = 1'b1;
                d = dat_o;
            end
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bit got = 1'b0;
        adr_i = a; dat_i = d; we_i = 1'b1; sel_i = 4'h1; stb_i = 1'b1; cyc_i = 1'b1;
        for (int n = 0; n < 4 && !got; n++) begin
            tick();
            got = ack_o;
        end
        vectors++;
        if (!got) begin
            $display("FAIL write_ack: no ack for write to offset %0d", a);
            miscompares++;
        end
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_i = 1'b1;
        tick(); tick();
        vectors++;
        if (interrupt !== 3'd0 || ack_o !== 1'b0 || dat_o !== 32'd0) begin
            $display("FAIL reset_outputs: int=%0d ack=%b dat=%h expected 0/0/0", interrupt, ack_o, dat_o);
            miscompares++;
        end
        rst_i = 1'b0;
        tick();
        // Hold the strobe for two edges: ack must appear once, then drop.
        adr_i = IRQ_MASK; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
        tick();
        vectors++;
        if (ack_o !== 1'b1 || dat_o !== 32'h7F) begin
            $display("FAIL ack_pulse_first: ack=%b dat=%h expected 1/0000007f", ack_o, dat_o);
            miscompares++;
        end
        tick();
        vectors++;
        if (ack_o !== 1'b0 || dat_o !== 32'd0) begin
            $display("FAIL ack_pulse_second: ack=%b dat=%h expected 0/00000000", ack_o, dat_o);
            miscompares++;
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        tick();
        bus_read(IRQ_EDGE, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL reset_edge: read %h expected 00000000", d);
            miscompares++;
        end
    endtask

    task automatic test_level();
        logic [31:0] d;
        int_en = 1'b1;
        irq_i = 7'b0000110;
        tick();
        vectors++;
        if (interrupt !== 3'd0) begin
            $display("FAIL level_latency: interrupt=%0d expected 0 after first edge", interrupt);
            miscompares++;
        end
        tick();
        vectors++;
        if (interrupt !== 3'd2) begin
            $display("FAIL level_timer0: interrupt=%0d expected 2", interrupt);
            miscompares++;
        end
        irq_i = 7'b0000010;
        tick(); tick();
        vectors++;
        if (interrupt !== 3'd6) begin
            $display("FAIL level_uart_rx: interrupt=%0d expected 6", interrupt);
            miscompares++;
        end
        bus_read(IRQ_ACTIVE, d);
        vectors++;
        if (d !== 32'd6) begin
            $display("FAIL active_read: read %h expected 00000006", d);
            miscompares++;
        end
        bus_read(IRQ_STATUS, d);
        vectors++;
        if (d !== 32'h02) begin
            $display("FAIL status_read: read %h expected 00000002", d);
            miscompares++;
        end
        irq_i = 7'b0;
        tick(); tick();
        vectors++;
        if (interrupt !== 3'd0) begin
            $display("FAIL level_release: interrupt=%0d expected 0", interrupt);
            miscompares++;
        end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        bus_write(IRQ_EDGE, 32'h01);
        bus_read(IRQ_EDGE, d);
        vectors++;
        if (d !== 32'h01) begin
            $display("FAIL edge_readback: read %h expected 00000001", d);
            miscompares++;
        end
        irq_i = 7'b0000001;
        tick();
        irq_i = 7'b0;
        tick();
        vectors++;
        if (interrupt !== 3'd0) begin
            $display("FAIL edge_latency: interrupt=%0d expected 0 one edge early", interrupt);
            miscompares++;
        end
        tick();
        vectors++;
        if (interrupt !== 3'd7) begin
            $display("FAIL edge_uart_tx: interrupt=%0d expected 7", interrupt);
            miscompares++;
        end
        bus_read(IRQ_PENDING, d);
        vectors++;
        if (d !== 32'h01 || interrupt !== 3'd7) begin
            $display("FAIL edge_sticky: pending=%h int=%0d expected 00000001/7", d, interrupt);
            miscompares++;
        end
        bus_write(IRQ_CLEAR, 32'h01);
        vectors++;
        if (interrupt !== 3'd0) begin
            $display("FAIL edge_clear_int: interrupt=%0d expected 0", interrupt);
            miscompares++;
        end
        bus_read(IRQ_PENDING, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL edge_clear_pending: read %h expected 00000000", d);
            miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        // irq_q is high and irq_qq low at the same edge that the CLEAR write lands.
        irq_i = 7'b0000001;
        tick();
        adr_i = IRQ_CLEAR; dat_i = 32'h01; we_i = 1'b1; sel_i = 4'h1; stb_i = 1'b1; cyc_i = 1'b1;
        tick();
        vectors++;
        if (ack_o !== 1'b1) begin
            $display("FAIL race_ack: ack=%b expected 1", ack_o);
            miscompares++;
        end
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; irq_i = 7'b0;
        tick();
        bus_read(IRQ_PENDING, d);
        vectors++;
        if (d !== 32'h01) begin
            $display("FAIL race_set_wins: pending=%h expected 00000001", d);
            miscompares++;
        end
        bus_write(IRQ_CLEAR, 32'h01);
        bus_read(IRQ_PENDING, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL race_cleanup: pending=%h expected 00000000", d);
            miscompares++;
        end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        bus_write(IRQ_EDGE, 32'h7F);
        bus_read(IRQ_EDGE, d);
        vectors++;
        if (d !== 32'h3F) begin
            $display("FAIL edge_mmu_fixed: read %h expected 0000003f", d);
            miscompares++;
        end
        bus_write(IRQ_EDGE, 32'h00);
        bus_write(IRQ_MASK, 32'h00);
        bus_read(IRQ_MASK, d);
        vectors++;
        if (d !== 32'h40) begin
            $display("FAIL mask_mmu_fixed: read %h expected 00000040", d);
            miscompares++;
        end
        irq_i = 7'b0000100;
        tick(); tick(); tick();
        vectors++;
        if (interrupt !== 3'd0) begin
            $display("FAIL mask_suppress: interrupt=%0d expected 0", interrupt);
            miscompares++;
        end
        irq_i = 7'b1100000;
        tick(); tick();
        vectors++;
        if (interrupt !== 3'd1) begin
            $display("FAIL mmu_nonmaskable: interrupt=%0d expected 1", interrupt);
            miscompares++;
        end
        int_en = 1'b0;
        tick();
        vectors++;
        if (interrupt !== 3'd0) begin
            $display("FAIL int_en_off: interrupt=%0d expected 0", interrupt);
            miscompares++;
        end
        irq_i = 7'b0;
        int_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(IRQ_MASK, 32'h07);
        bus_write(IRQ_EDGE, 32'h0F);
        irq_i = 7'b0001111;
        tick();
        irq_i = 7'b0;
        tick(); tick();
        vectors++;
        if (interrupt !== 3'd2) begin
            $display("FAIL premask_int: interrupt=%0d expected 2", interrupt);
            miscompares++;
        end
        bus_read(IRQ_PENDING, d);
        vectors++;
        if (d !== 32'h0F) begin
            $display("FAIL pending_multi: read %h expected 0000000f", d);
            miscompares++;
        end
        adr_i = IRQ_MASK; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b1;
        rst_i = 1'b1;
        tick();
        vectors++;
        if (ack_o !== 1'b0 || dat_o !== 32'd0 || interrupt !== 3'd0) begin
            $display("FAIL reset_in_cycle: ack=%b dat=%h int=%0d expected 0/0/0", ack_o, dat_o, interrupt);
            miscompares++;
        end
        rst_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
        tick();
        bus_read(IRQ_MASK, d);
        vectors++;
        if (d !== 32'h7F) begin
            $display("FAIL reset_mask: read %h expected 0000007f", d);
            miscompares++;
        end
        bus_read(IRQ_EDGE, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL reset_edge_mid: read %h expected 00000000", d);
            miscompares++;
        end
        bus_read(IRQ_PENDING, d);
        vectors++;
        if (d !== 32'd0 || interrupt !== 3'd0) begin
            $display("FAIL reset_pending: pending=%h int=%0d expected 00000000/0", d, interrupt);
            miscompares++;
        end
        bus_write(3'd6, 32'h7F);
        bus_read(3'd6, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL reserved_read: read %h expected 00000000", d);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_simultaneous();
        test_mask();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Registered interrupt controller that replaces the combinational priority encoder in the max10 top level.
- It sits directly upstream of the bexkat2 CPU: it takes raw MMU-fault and iocontroller interrupt lines and drives the CPU's 3-bit interrupt code.
- It adds per-source mask, per-source edge/level mode and sticky edge-pending bits.
- It is a Wishbone slave on its own chipselect, so software can inspect, mask and clear sources.

Parameters:
- NSRC, 7, number of interrupt sources; bit 6 = MMU fault, bits 5..0 = io_interrupts.
- MASK_RESET, 7'h7F, reset value of the MASK register (all sources enabled).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset; synchronous, active-high.
- adr_i  input  3  word address (cpu_address[4:2]).
- dat_i  input  32  write data.
- dat_o  output  32  read data.
- we_i  input  1  write enable.
- sel_i  input  4  byte selects; only sel_i[0] is honoured.
- stb_i  input  1  strobe (chipselect decode).
- cyc_i  input  1  bus cycle.
- ack_o  output  1  bus acknowledge.
- irq_i  input  NSRC  raw interrupt requests, active-high, synchronous to clk_i.
- int_en  input  1  CPU global interrupt enable.
- interrupt  output  3  priority-encoded interrupt code to the CPU; 0 = none.

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge): interrupt=0, ack_o=0, dat_o=0, pending=0, edge=0, mask=MASK_RESET, irq_q=0, irq_qq=0. Reset asserted mid bus cycle drops ack_o; no register write occurs that cycle.
- Sampling: irq_q <= irq_i and irq_qq <= irq_q on every edge.
- Edge mode (edge[i]=1):
  - pending[i] sets when irq_q[i] & ~irq_qq[i].
  - pending[i] clears only via a CLEAR write.
  - Simultaneous set and clear on the same edge: set wins, so no event is lost.
- Level mode (edge[i]=0): pending[i] is unused and held at 0; the source value is irq_q[i].
- Bit 6 (MMU) is fixed: level mode, non-maskable. mask[6] and edge[6] read 1 and 0 respectively; writes to them are ignored.
- Effective vector: eff = mask & (edge ? pending : irq_q).
- Output: interrupt <= int_en ? encode(eff) : 0, registered.
- Priority, highest first, with codes:
  - bit6 -> 1
  - bit5 -> 5
  - bit4 -> 4
  - bit3 -> 3
  - bit2 -> 2
  - bit1 -> 6
  - bit0 -> 7
  - none -> 0
- Latency from irq_i rising before edge N:
  - level mode: interrupt valid after edge N+1.
  - edge mode: interrupt valid after edge N+2.
  - int_en falling: interrupt=0 after the next edge.
- Bus handshake:
  - ack_o <= stb_i & cyc_i & ~ack_o, giving a one-cycle pulse with one wait state.
  - Back-to-back accesses therefore take 2 cycles each.
- Reads: dat_o is registered on the same edge that asserts ack_o and is 0 in all other cycles.
- Writes:
  - Take effect on the edge that asserts ack_o, only if we_i and sel_i[0] are set.
  - Data is dat_i[6:0]; all other bits are ignored.
- Register map (word offset):
  - 0 STATUS (RO) = {25'b0, irq_q}.
  - 1 PENDING (RO) = {25'b0, pending}.
  - 2 MASK (RW).
  - 3 EDGE (RW).
  - 4 CLEAR (WO): writing 1s clears the matching pending bits; reads return 0.
  - 5 ACTIVE (RO) = {29'b0, interrupt}.
  - 6..7 reserved: reads return 0, writes are ignored.
- Switching edge[i] from 1 to 0 clears pending[i] on the same edge.
- Clearing mask[i] suppresses the source in the output but does not clear pending[i].

Decomposition:
- Shared package bexkat_irq_pkg holds:
  - register offset constants (IRQ_STATUS .. IRQ_ACTIVE);
  - the source-index constants (SRC_MMU=6, SRC_TIMER3..0=5..2, SRC_UART_RX=1, SRC_UART_TX=0);
  - the per-source code table as a constant array.
- One sub-module, irq_prio_encode: combinational, NSRC-bit vector in, 3-bit code out, table-driven from the package.

Test Plan:
- Reset, then read MASK and EDGE -> 32'h7F and 0; interrupt=0; ack_o pulses exactly 1 cycle after stb_i&cyc_i.
- Level mode: raise irq_i[2] (timer0) and irq_i[1] together with int_en=1 -> interrupt=2 two edges after assertion; drop irq_i[2] -> interrupt=6; drop irq_i[1] -> 0.
- Edge mode: write EDGE=7'h01, pulse irq_i[0] for 1 cycle -> PENDING=1, interrupt=7 (held); write CLEAR=1 -> PENDING=0, interrupt=0 next edge.
- Simultaneous events: CLEAR write to bit 0 on the same edge as a new rising edge on irq_i[0] -> PENDING[0] remains 1.
- Mask and non-maskable MMU: write MASK=0 -> timer interrupts suppressed and MASK reads 7'h40; assert irq_i[6] with irq_i[5] -> interrupt=1; int_en=0 -> 0 next edge.
- Reset mid-operation: pending=7'h0F with interrupt=2, assert rst_i for 1 cycle during an active bus read -> ack_o=0, all registers return to reset values, interrupt=0.
